// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit operands are summed
// CHUNK bits per clock, LSB chunk first, behind valid/ready handshakes.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] av,
  input  logic [WIDTH-1:0] bv,
  input  logic             M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultsv,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_serial: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state_r;
  logic [CW-1:0]    count_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  logic [BW-1:0]    base_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   sum_s;
  logic [WIDTH-1:0] res_next_s;

  // One chunk of the ripple: the result word with the current chunk filled in
  always_comb begin
    base_s     = BW'(count_r * CHUNK);
    a_chunk_s  = a_r[base_s +: CHUNK];
    b_chunk_s  = b_r[base_s +: CHUNK];
    sum_s      = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    res_next_s = result_r;
    res_next_s[base_s +: CHUNK] = sum_s[CHUNK-1:0];
  end

  // Handshake FSM, operand capture, chunk accumulation and final flag latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      carry_r  <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1; the +1 rides in as the first carry
            a_r     <= av;
            b_r     <= bv ^ {WIDTH{M}};
            carry_r <= M;
            count_r <= {CW{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          result_r <= res_next_s;
          carry_r  <= sum_s[CHUNK];
          if (count_r == LAST) begin
            cout_r  <= sum_s[CHUNK];
            ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
            zero_r  <= (res_next_s == {WIDTH{1'b0}});
            neg_r   <= res_next_s[WIDTH-1];
            state_r <= DONE;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign resultsv  = result_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign neg       = neg_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: four builds (CHUNK 16/8/4/1) share stimulus and are checked
// against an arithmetic A+/-B model for result, flags, latency and handshake.
module tb_addsub_serial;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic         M;
  logic [W-1:0] av;
  logic [W-1:0] bv;

  logic         in_ready_s  [N];
  logic         out_valid_s [N];
  logic [W-1:0] res_s       [N];
  logic         cout_s      [N];
  logic         ovf_s       [N];
  logic         zero_s      [N];
  logic         neg_s       [N];

  logic [19:0]  exp_q [$];
  int           checks = 0;
  int           passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int C = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 4 : 1;
    addsub_serial #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s[g]),
      .av(av), .bv(bv), .M(M), .out_valid(out_valid_s[g]), .out_ready(out_ready),
      .resultsv(res_s[g]), .cout(cout_s[g]), .ovf(ovf_s[g]), .zero(zero_s[g]), .neg(neg_s[g])
    );
  end

  function automatic int chunk_of(input int i);
    case (i)
      0: return 16;
      1: return 8;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  // Packed {cout, ovf, zero, neg, result} from plain integer arithmetic
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
    int ua, ub, sa, sb, sr;
    logic [15:0] r;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m) begin
      r  = 16'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = 16'(ua + ub);
      c  = ((ua + ub) > 65535);
      sr = sa + sb;
    end
    o = (sr > 32767) || (sr < -32768);
    return {c, o, (r == 16'h0000), r[15], r};
  endfunction

  function automatic logic [19:0] got_of(input int i);
    return {cout_s[i], ovf_s[i], zero_s[i], neg_s[i], res_s[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int  t;
    bit  all_rdy;
    t = 0;
    all_rdy = 1'b0;
    while (!all_rdy && t < 50) begin
      all_rdy = 1'b1;
      for (int i = 0; i < N; i++) if (!in_ready_s[i]) all_rdy = 1'b0;
      if (!all_rdy) begin
        @(negedge clk);
        t++;
      end
    end
    check("in_ready wait", 32'(all_rdy), 32'd1);
  endtask

  // Called and returns at a falling edge
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m, input int hold);
    int          lat [N];
    bit          all_valid;
    logic [19:0] exp;
    wait_ready();
    av = a;
    bv = b;
    M = m;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b, m));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    av = 16'($urandom);
    bv = 16'($urandom);
    M = 1'($urandom);
    for (int i = 0; i < N; i++) lat[i] = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      all_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (out_valid_s[i] && lat[i] < 0) lat[i] = k;
        if (!out_valid_s[i]) all_valid = 1'b0;
      end
      if (all_valid) break;
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      check($sformatf("latency c%0d", chunk_of(i)), 32'(lat[i]), 32'(W / chunk_of(i)));
      check($sformatf("result c%0d a=%h b=%h m=%0d", chunk_of(i), a, b, m), 32'(got_of(i)), 32'(exp));
    end
    repeat (hold) begin
      in_valid = 1'b1;
      av = 16'($urandom);
      bv = 16'($urandom);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("bp hold c%0d", chunk_of(i)), 32'(got_of(i)), 32'(exp));
        check($sformatf("bp in_ready c%0d", chunk_of(i)), 32'(in_ready_s[i]), 32'd0);
        check($sformatf("bp out_valid c%0d", chunk_of(i)), 32'(out_valid_s[i]), 32'd1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("release in_ready c%0d", chunk_of(i)), 32'(in_ready_s[i]), 32'd1);
      check($sformatf("release out_valid c%0d", chunk_of(i)), 32'(out_valid_s[i]), 32'd0);
      check($sformatf("release hold c%0d", chunk_of(i)), 32'(got_of(i)), 32'(exp));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    M = 1'b0;
    av = 16'h0000;
    bv = 16'h0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset in_ready", 32'(in_ready_s[i]), 32'd1);
      check("reset out_valid", 32'(out_valid_s[i]), 32'd0);
      check("reset outputs", 32'(got_of(i)), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    do_op(16'h1234, 16'h0FFF, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 3);
    do_op(16'h0000, 16'h0000, 1'b1, 0);

    // Abort two edges into RUN: reset must act without a clock edge
    wait_ready();
    av = 16'hFFFF;
    bv = 16'hFFFF;
    M = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check("async reset in_ready", 32'(in_ready_s[i]), 32'd1);
      check("async reset out_valid", 32'(out_valid_s[i]), 32'd0);
      check("async reset outputs", 32'(got_of(i)), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
